// File: rtl/pixel_ctrl_pkg.sv
// rtl/pixel_ctrl_pkg.sv - shared types, sizes and code helpers for the pixel array sequencer
package pixel_ctrl_pkg;

  localparam int N_PIXELS = 4;
  localparam int CODE_W   = 8;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_SETTLE,
    S_OUT
  } state_t;

  function automatic logic [CODE_W-1:0] gray_enc(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CODE_W-1:0] gray_dec(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b[CODE_W-1] = g[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Undriven or unknown bus bits read as 0, so an untripped pixel reports code 0.
  function automatic logic [CODE_W-1:0] bus_clean(input logic [CODE_W-1:0] d);
    logic [CODE_W-1:0] c;
    for (int i = 0; i < CODE_W; i++) begin
      c[i] = (d[i] === 1'b1);
    end
    return c;
  endfunction

endpackage

// File: rtl/pixel_array_ctrl_conv_counter.sv
// rtl/pixel_array_ctrl_conv_counter.sv - saturating 8-bit ramp code counter (Gray output under PIXEL_CTRL_GRAY_EN)
module conv_counter
  import pixel_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [CODE_W-1:0] code,
  output logic              tc
);

  logic [CODE_W-1:0] cnt_q;
  logic [CODE_W-1:0] cnt_d;

  assign tc = (cnt_q == {CODE_W{1'b1}});

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The bus code is registered from the next count so it lines up with cnt_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      code  <= '0;
    end else begin
      cnt_q <= cnt_d;
`ifdef PIXEL_CTRL_GRAY_EN
      code  <= gray_enc(cnt_d);
`else
      code  <= cnt_d;
`endif
    end
  end

endmodule

// File: rtl/pixel_array_ctrl.sv
// rtl/pixel_array_ctrl.sv - frame sequencer: erase/expose/convert/read with streamed pixel codes (PIXEL_CTRL_GRAY_EN)
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int C_ERASE  = 5,
  parameter int C_EXPOSE = 255,
  parameter int C_SETTLE = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  output logic                PIX_RESET,
  output logic                ERASE,
  output logic                EXPOSE,
  output logic                CONVERT,
  output logic [N_PIXELS-1:0] READ,
  inout  wire  [CODE_W-1:0]   DATA,
  output logic [CODE_W-1:0]   PIXEL_DATA,
  output logic [1:0]          PIXEL_IDX,
  output logic                PIXEL_VALID,
  input  logic                PIXEL_READY,
  output logic                BUSY,
  output logic                FRAME_DONE
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          idx_q, idx_d;
  logic [CODE_W-1:0]   code;
  logic                code_tc;
  logic [CODE_W-1:0]   cap;

  logic                erase_d, expose_d, convert_d, valid_d, busy_d, done_d, capture;
  logic [N_PIXELS-1:0] read_d;

  conv_counter u_conv_counter (
    .clk   (CLK),
    .rst_n (RESET),
    .clr   (state_q != S_CONVERT),
    .en    (state_q == S_CONVERT),
    .code  (code),
    .tc    (code_tc)
  );

  assign DATA = CONVERT ? code : 'z;

`ifdef PIXEL_CTRL_GRAY_EN
  assign cap = gray_dec(bus_clean(DATA));
`else
  assign cap = bus_clean(DATA);
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      PIX_RESET   <= 1'b0;
      ERASE       <= 1'b0;
      EXPOSE      <= 1'b0;
      CONVERT     <= 1'b0;
      READ        <= '0;
      PIXEL_VALID <= 1'b0;
      BUSY        <= 1'b0;
      FRAME_DONE  <= 1'b0;
      PIXEL_DATA  <= '0;
      PIXEL_IDX   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q != S_IDLE) begin
        cnt_q <= cnt_q + 1'b1;
      end
      PIX_RESET   <= erase_d;
      ERASE       <= erase_d;
      EXPOSE      <= expose_d;
      CONVERT     <= convert_d;
      READ        <= read_d;
      PIXEL_VALID <= valid_d;
      BUSY        <= busy_d;
      FRAME_DONE  <= done_d;
      if (capture) begin
        PIXEL_DATA <= cap;
        PIXEL_IDX  <= idx_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE:    if (START) state_d = S_ERASE;
      S_ERASE:   if (cnt_q == CNT_W'(C_ERASE - 1)) state_d = S_EXPOSE;
      S_EXPOSE:  if (cnt_q == CNT_W'(C_EXPOSE - 1)) state_d = S_CONVERT;
      S_CONVERT: begin
        if (code_tc) begin
          state_d = S_SETTLE;
          idx_d   = '0;
        end
      end
      S_SETTLE:  if (cnt_q == CNT_W'(C_SETTLE - 1)) state_d = S_OUT;
      S_OUT: begin
        // PIXEL_VALID is always high in OUT, so READY alone completes the handshake.
        if (PIXEL_READY) begin
          if (idx_q == 2'(N_PIXELS - 1)) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_SETTLE;
          end
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they switch on the transition edge.
  always_comb begin
    erase_d   = (state_d == S_ERASE);
    expose_d  = (state_d == S_EXPOSE);
    convert_d = (state_d == S_CONVERT);
    read_d    = '0;
    if (state_d == S_SETTLE || state_d == S_OUT) begin
      read_d = N_PIXELS'(1) << idx_d;
    end
    valid_d   = (state_d == S_OUT);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_OUT) && (state_d == S_IDLE);
    capture   = (state_q == S_SETTLE) && (state_d == S_OUT);
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb/tb_pixel_array_ctrl.sv - scoreboard bench for pixel_array_ctrl with a behavioural pixel array model
module tb_pixel_array_ctrl;

  localparam int CE = 5;
  localparam int CX = 10;
  localparam int CS = 2;
  localparam int FRAME_LEN = 1 + CE + CX + 256 + 4 * (CS + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic       pix_reset, erase, expose, convert, valid, busy, done;
  logic [3:0] read;
  logic [7:0] pdata;
  logic [1:0] pidx;
  wire  [7:0] data_bus;

  logic [7:0] drv_val;
  logic       drv_en;
  logic       probe_en = 1'b0;
  logic [7:0] probe_val = 8'h00;

  int         vecs = 0;
  int         miss = 0;
  int         cyc = 0;

  int         tgt [4];
  logic [7:0] lat [4];
  logic [3:0] lat_ok = '0;
  int         conv_k = 0;
  logic [9:0] exp_q [$];

  bit         frame_active = 0;
  bit         chk_len = 0;
  int         t_start = 0;
  int         done_cnt = 0;
  int         stall_seen = 0;
  int         stall_n = 0;
  int         ready_mode = 0;
  int         rr_cyc = 0;

  bit          prev_fd, prev_hs, prev_last, prev_hold, prev_valid;
  logic [13:0] prev_snap;
  logic [3:0]  prev_read;
  int          o;
  bit          e, x, c;

  pixel_array_ctrl #(.C_ERASE(CE), .C_EXPOSE(CX), .C_SETTLE(CS)) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .START       (start),
    .PIX_RESET   (pix_reset),
    .ERASE       (erase),
    .EXPOSE      (expose),
    .CONVERT     (convert),
    .READ        (read),
    .DATA        (data_bus),
    .PIXEL_DATA  (pdata),
    .PIXEL_IDX   (pidx),
    .PIXEL_VALID (valid),
    .PIXEL_READY (ready),
    .BUSY        (busy),
    .FRAME_DONE  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel array: a selected pixel drives its latched code; untripped pixels stay off the bus.
  always_comb begin
    drv_en  = probe_en;
    drv_val = probe_val;
    for (int i = 0; i < 4; i++) begin
      if (read[i] && lat_ok[i]) begin
        drv_en  = 1'b1;
        drv_val = lat[i];
      end
    end
  end
  assign data_bus = drv_en ? drv_val : 8'bz;

  function automatic logic [7:0] code_of(input int k);
    logic [7:0] b;
    b = k[7:0];
`ifdef PIXEL_CTRL_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (convert) begin
      for (int i = 0; i < 4; i++) begin
        if (tgt[i] == conv_k) begin
          lat[i]    = data_bus;
          lat_ok[i] = 1'b1;
        end
      end
      conv_k++;
    end else begin
      conv_k = 0;
    end

    if (rst_n) begin
      chk("convert_read_overlap", {31'd0, convert && (read != 4'd0)}, 0);
      if (prev_fd) chk("done_pulse", {31'd0, done}, 0);
      if (prev_hs && !prev_last) chk("valid_drop", {31'd0, valid}, 0);
      if (prev_hold) begin
        chk("hold_valid", {31'd0, valid}, 1);
        chk("hold_stable", {18'd0, pidx, pdata, read}, {18'd0, prev_snap});
      end
      if (read != prev_read && read != 4'd0) rr_cyc = cyc;
      if (valid && !prev_valid) chk("settle_latency", cyc - rr_cyc, CS);
      if (valid) begin
        chk("read_sel", {28'd0, read}, {28'd0, 4'd1 << pidx});
        if (ready) begin
          if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
          else chk("pixel", {22'd0, pidx, pdata}, {22'd0, exp_q.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        chk("sb_drained", exp_q.size(), 0);
        chk("busy_at_done", {31'd0, busy}, 0);
        if (chk_len) chk("frame_len", cyc - t_start, FRAME_LEN);
        frame_active = 0;
      end else if (frame_active) begin
        o = cyc - t_start;
        e = (o >= 1) && (o <= CE);
        x = (o > CE) && (o <= CE + CX);
        c = (o > CE + CX) && (o <= CE + CX + 256);
        chk("strobes", {28'd0, pix_reset, erase, expose, convert}, {28'd0, e, e, x, c});
        chk("busy", {31'd0, busy}, {31'd0, o >= 1});
        if (c) chk("data_code", {24'd0, data_bus}, {24'd0, code_of(o - CE - CX - 1)});
      end else begin
        chk("idle", {28'd0, busy, erase, expose, convert}, 0);
      end
      if (valid && !ready && pidx == 2'd1) stall_seen++;
      prev_fd    = done;
      prev_hs    = valid && ready;
      prev_last  = (pidx == 2'd3);
      prev_hold  = valid && !ready;
      prev_valid = valid;
      prev_read  = read;
      prev_snap  = {pidx, pdata, read};
    end else begin
      prev_fd = 0; prev_hs = 0; prev_hold = 0; prev_valid = 0; prev_read = '0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) ready = 1'b1;
      else if (valid && pidx == 2'd1 && stall_n < 20) begin
        ready = 1'b0;
        stall_n++;
      end else ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic start_frame(input int t0, input int t1, input int t2, input int t3, input bit len);
    tgt[0] = t0; tgt[1] = t1; tgt[2] = t2; tgt[3] = t3;
    lat_ok = '0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'(i), (tgt[i] < 0) ? 8'd0 : 8'(tgt[i])});
    end
    t_start      = cyc;
    frame_active = 1;
    chk_len      = len;
    start        = 1'b1;
    @(posedge clk); #2;
    start        = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin
      @(posedge clk); #2;
      n++;
    end
    if (!done) chk("timeout_frame_done", 0, 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ctrl"}, {20'd0, pix_reset, erase, expose, convert, read, valid, busy, done, 1'b0},
        32'd0);
    chk({nm, "_pixel"}, {22'd0, pidx, pdata}, 32'd0);
    probe_val = 8'h5A;
    probe_en  = 1'b1;
    #1;
    chk({nm, "_bus_released"}, {24'd0, data_bus}, 32'h5A);
    probe_en  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      tgt[i] = -1;
      lat[i] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    ready_mode = 0;
    start_frame(8'h03, 8'h80, 8'h99, 8'hFF, 1);
    wait_done(2000);

    @(posedge clk); #2;
    ready_mode = 1;
    stall_n    = 0;
    stall_seen = 0;
    start_frame($urandom_range(0, 255), $urandom_range(0, 255), -1, $urandom_range(0, 255), 0);
    repeat (CE + 3) @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int n = 0; n < 2000 && !valid; n++) begin
      @(posedge clk); #2;
    end
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(2000);
    @(posedge clk); #2;
    chk("done_count_f2", done_cnt, 2);
    chk("stall_pixel1", {31'd0, stall_seen >= 20}, 1);

    stall_n = 20;
    start_frame($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), 0);
    repeat (CE + CX + 100) @(posedge clk);
    #2;
    frame_active = 0;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    ready_mode = 0;
    start_frame($urandom_range(0, 255), -1, $urandom_range(0, 255), $urandom_range(0, 255), 1);
    wait_done(2000);
    @(posedge clk); #2;
    chk("done_count_final", done_cnt, 3);

    ready_mode = 1;
    start_frame($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), 0);
    wait_done(3000);
    @(posedge clk); #2;
    chk("done_count_rand", done_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

Frame sequencer for the 4-pixel array: drives the pixel control strobes through erase, expose, convert and read phases. During convert it generates the shared 8-bit code that each pixel latches when its comparator trips. During read it selects each pixel in turn and streams the latched codes out over a valid/ready interface. Sits between the system/readout logic and the pixel array, and is the only driver of the array's control inputs and of DATA outside the read phase.

## Interface
- C_ERASE, 5: erase phase length in cycles (1–255)
- C_EXPOSE, 255: expose phase length in cycles (1–65535)
- C_SETTLE, 2: cycles READ[i] is held before DATA is sampled (1–15)
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- START  in  1  frame request; sampled only in IDLE
- PIX_RESET  out  1  to the array's RESET input
- ERASE  out  1  to the array's ERASE input
- EXPOSE  out  1  to the array's EXPOSE input
- CONVERT  out  1  to the array's CONVERT input
- READ  out  4  one-hot pixel select, to the array's READ
- DATA  inout  8  shared code bus; driven only while CONVERT=1, else high-Z
- PIXEL_DATA  out  8  read-out code
- PIXEL_IDX  out  2  pixel index of PIXEL_DATA
- PIXEL_VALID  out  1  PIXEL_DATA/PIXEL_IDX valid
- PIXEL_READY  in  1  consumer accepts when VALID & READY
- BUSY  out  1  high in every state except IDLE
- FRAME_DONE  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, SETTLE, OUT.
- One phase counter is shared by all states.
  - It loads 0 on every state entry.
  - Its width is sufficient for C_EXPOSE.
- IDLE:
  - All strobes are 0.
  - START=1 moves to ERASE next cycle.
  - START in any other state is ignored; no queuing.
- ERASE:
  - ERASE=1 and PIX_RESET=1 for exactly C_ERASE cycles.
  - Then moves to EXPOSE.
- EXPOSE:
  - EXPOSE=1 for exactly C_EXPOSE cycles.
  - Then moves to CONVERT.
- CONVERT:
  - CONVERT=1 for exactly 256 cycles.
  - DATA carries code k in the k-th cycle, k = 0..255.
  - The counter is 8-bit and stops at 255; it never wraps within a frame.
  - Then moves to SETTLE with pixel index 0.
- SETTLE:
  - READ = 1<<idx, held for C_SETTLE cycles.
  - DATA is released (high-Z) on the first SETTLE cycle.
  - On the last SETTLE cycle, DATA is captured into PIXEL_DATA and the state moves to OUT.
- OUT:
  - READ is still held and PIXEL_VALID=1.
  - PIXEL_DATA and PIXEL_IDX are stable until the handshake.
  - On VALID & READY with idx<3: idx increments, VALID drops, and the state moves to SETTLE.
  - On VALID & READY with idx=3: FRAME_DONE pulses and the state moves to IDLE.
- PIXEL_DATA capture: any X/Z bit on DATA is captured as 0, i.e. a pixel that never tripped reads as 0.
- Reset mid-frame: all state is discarded immediately, the block returns to IDLE, and DATA is released.

## Timing
- Reset values:
  - PIX_RESET, ERASE, EXPOSE, CONVERT: 0
  - READ: 4'b0000
  - PIXEL_VALID, BUSY, FRAME_DONE: 0
  - PIXEL_DATA, PIXEL_IDX: 0
  - DATA: high-Z
- All outputs are registered. Strobes change on the clock edge of the state transition.
- START at edge t:
  - ERASE=1 from t+1 through t+C_ERASE.
  - EXPOSE=1 from t+C_ERASE+1.
- Strobes never overlap. ERASE and EXPOSE are adjacent with no gap; the same holds for EXPOSE and CONVERT.
- CONVERT and READ are never both 1. DATA is never driven while any READ bit is 1.
- PIXEL_VALID rises C_SETTLE cycles after READ[idx] rises.
- Frame length with READY tied 1: 1 + C_ERASE + C_EXPOSE + 256 + 4·(C_SETTLE+1) cycles from START to FRAME_DONE.
- FRAME_DONE and the return to IDLE coincide. START is accepted again the cycle after FRAME_DONE.

## Configuration
- Macro: PIXEL_CTRL_GRAY_EN.
- Defined:
  - DATA carries the Gray code of k, i.e. k ^ (k>>1).
  - Captured codes are converted Gray→binary before PIXEL_DATA, so PIXEL_DATA values are identical to the binary build.
- Undefined: DATA carries plain binary k; no conversion.

## Structure
- Package pixel_ctrl_pkg holds:
  - state enum type
  - N_PIXELS=4, CODE_W=8
  - Gray encode/decode functions
- Sub-module conv_counter:
  - 8-bit ramp-code counter with clear and enable, plus a saturating terminal flag.
  - Gray output option under PIXEL_CTRL_GRAY_EN.

## Test plan
- Reset, then START with C_ERASE=5, C_EXPOSE=10, C_SETTLE=2, READY=1 -> ERASE high exactly 5 cycles, EXPOSE 10, CONVERT 256; FRAME_DONE after 284 cycles total.
- Array model latching 0x03, 0x80, 0x99, 0xFF -> PIXEL_DATA stream 0x03, 0x80, 0x99, 0xFF with IDX 0..3; repeat with PIXEL_CTRL_GRAY_EN defined and expect identical values.
- READY held 0 for 20 cycles on pixel 1 -> VALID, DATA, IDX and READ=4'b0010 stay stable for all 20 cycles; pixel 2 not selected until the handshake.
- START pulsed during EXPOSE and during OUT -> ignored; exactly one FRAME_DONE; a new START the cycle after FRAME_DONE starts ERASE.
- RESET asserted mid-CONVERT -> all outputs at reset values, DATA high-Z within the same cycle; next START runs a full, correct frame.
- Pixel model never trips (DATA Z during read) -> PIXEL_DATA 0x00 for that index; bus-contention checker reports no conflict across the frame.
